// File: rtl/div_sched_pkg.sv
// div_sched_pkg: shared state encoding and constants for the round-robin divider scheduler
package div_sched_pkg;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  localparam int DEF_WIDTH = 4;
  localparam logic DBZ_FILL = 1'b1;
  function automatic int wrap_add(int a, int b, int n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/div_rr_scheduler_if.sv
// div_rr_scheduler_if: request and response channels between requesters/consumer and the scheduler
interface div_rr_scheduler_if #(
  parameter int WIDTH = div_sched_pkg::DEF_WIDTH,
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) ();
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*WIDTH-1:0] req_dividend;
  logic [N_REQ*WIDTH-1:0] req_divisor;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [ID_W-1:0]        rsp_id;
  logic [WIDTH-1:0]       rsp_quotient;
  logic [WIDTH-1:0]       rsp_remainder;
  logic                   rsp_dbz;
  logic                   busy;
  modport master (
    output req_valid, req_dividend, req_divisor, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
  );
  modport slave (
    input  req_valid, req_dividend, req_divisor, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_quotient, rsp_remainder, rsp_dbz, busy
  );
endinterface

// File: rtl/div_iter_core.sv
// div_iter_core: restoring unsigned divider, one quotient bit per cycle, MSB first
module div_iter_core
  import div_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);
  localparam int CW = $clog2(WIDTH + 1);
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH:0]   w_sh;
  logic             w_ge;
  // dividend bits shift out of r_q's top while quotient bits enter at the bottom
  assign w_sh = {r_rem, r_q[WIDTH-1]};
  assign w_ge = w_sh >= {1'b0, r_d};
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_q   <= '0;
      r_d   <= '0;
    end else if (start) begin
      r_cnt <= CW'(WIDTH);
      r_rem <= '0;
      r_q   <= dividend;
      r_d   <= divisor;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      r_rem <= w_ge ? WIDTH'(w_sh - {1'b0, r_d}) : w_sh[WIDTH-1:0];
      r_q   <= {r_q[WIDTH-2:0], w_ge};
    end
  end
  assign done      = r_cnt == CW'(1);
  assign quotient  = r_q;
  assign remainder = r_rem;
endmodule

// File: rtl/div_rr_scheduler.sv
// div_rr_scheduler: round-robin arbitration of N_REQ requesters onto one shared iterative divider
module div_rr_scheduler
  import div_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_REQ = 2,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic clk,
  input  logic rst,
  div_rr_scheduler_if.slave bus
);
  state_t           r_state;
  logic [ID_W-1:0]  r_ptr;
  logic [ID_W-1:0]  r_id;
  logic             r_dbz;
  logic             r_rsp_valid;
  logic             r_busy;
  logic [ID_W-1:0]  w_grant;
  logic             w_any;
  logic             w_hs;
  logic             w_dz;
  logic             w_done;
  logic [WIDTH-1:0] w_dividend;
  logic [WIDTH-1:0] w_divisor;
  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_r;
  // scan downward so the nearest valid requester at or above the pointer wins
  always_comb begin
    w_grant = r_ptr;
    w_any   = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (bus.req_valid[wrap_add(int'(r_ptr), i, N_REQ)]) begin
        w_grant = ID_W'(wrap_add(int'(r_ptr), i, N_REQ));
        w_any   = 1'b1;
      end
  end
  assign w_hs          = !rst && r_state == IDLE && w_any;
  assign bus.req_ready = w_hs ? N_REQ'(1) << w_grant : '0;
  assign w_dividend    = bus.req_dividend[w_grant*WIDTH +: WIDTH];
  assign w_divisor     = bus.req_divisor[w_grant*WIDTH +: WIDTH];
  assign w_dz          = w_divisor == '0;
  div_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (w_hs && !w_dz),
    .dividend  (w_dividend),
    .divisor   (w_divisor),
    .done      (w_done),
    .quotient  (w_q),
    .remainder (w_r)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_dbz       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_id        <= w_grant;
          r_dbz       <= w_dz;
          r_busy      <= 1'b1;
          r_rsp_valid <= w_dz;
          r_state     <= w_dz ? DONE : CALC;
        end
        CALC: if (w_done) begin
          r_rsp_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: if (bus.rsp_ready) begin
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_ptr       <= r_id == ID_W'(N_REQ - 1) ? '0 : r_id + 1'b1;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  // results live in the core; a zero divisor masks them with the all-ones fill
  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.rsp_id        = r_id;
  assign bus.rsp_dbz       = r_dbz;
  assign bus.busy          = r_busy;
  assign bus.rsp_quotient  = r_dbz ? {WIDTH{DBZ_FILL}} : w_q;
  assign bus.rsp_remainder = r_dbz ? {WIDTH{DBZ_FILL}} : w_r;
endmodule

// File: tb/tb_div_rr_scheduler.sv
// tb_div_rr_scheduler: directed checks of arbitration, timing, divide-by-zero, backpressure and reset
module tb_div_rr_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  div_rr_scheduler_if #(.WIDTH(4), .N_REQ(2)) bus ();
  div_rr_scheduler #(.WIDTH(4), .N_REQ(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input int p, input int a, input int b, output int id, output int q, output int r, output int dz);
    int n;
    id = -1; q = -1; r = -1; dz = -1;
    bus.req_dividend[p*4 +: 4] = 4'(a);
    bus.req_divisor[p*4 +: 4] = 4'(b);
    bus.req_valid[p] = 1'b1;
    bus.rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!bus.req_ready[p] && n < 20) begin tick(); n++; end
    if (!bus.req_ready[p]) begin
      total++; bad++;
      $display("FAIL grant_timeout port=%0d got ready=%b want bit %0d set", p, bus.req_ready, p);
      bus.req_valid[p] = 1'b0;
    end else begin
      tick();
      bus.req_valid[p] = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 20) begin tick(); n++; end
      if (!bus.rsp_valid) begin
        total++; bad++;
        $display("FAIL rsp_timeout port=%0d got rsp_valid=0 want 1", p);
      end else begin
        id = int'(bus.rsp_id); q = int'(bus.rsp_quotient); r = int'(bus.rsp_remainder); dz = int'(bus.rsp_dbz);
        tick();
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.req_dividend = 8'h01; bus.req_divisor = 8'h11;
    bus.req_valid = 2'b01;
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", bus.req_ready); end
    tick(); tick();
    rst = 1'b0; bus.req_valid = 2'b00;
    #1;
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid got=%b want=0", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL rst_id got=%0d want=0", bus.rsp_id); end
    total++; if (bus.rsp_quotient !== 4'h0) begin bad++; $display("FAIL rst_q got=%h want=0", bus.rsp_quotient); end
    total++; if (bus.rsp_remainder !== 4'h0) begin bad++; $display("FAIL rst_r got=%h want=0", bus.rsp_remainder); end
    total++; if (bus.rsp_dbz !== 1'b0) begin bad++; $display("FAIL rst_dbz got=%b want=0", bus.rsp_dbz); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_single;
    bus.req_dividend[3:0] = 4'd13; bus.req_divisor[3:0] = 4'd4;
    bus.rsp_ready = 1'b1; bus.req_valid = 2'b01;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL single_ready got=%b want=01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    tick(); tick(); tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0 at T+4", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", bus.busy); end
    tick();
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1 at T+5", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 1'b0) begin bad++; $display("FAIL single_id got=%0d want=0", bus.rsp_id); end
    total++; if (bus.rsp_quotient !== 4'd3) begin bad++; $display("FAIL single_q got=%0d want=3", bus.rsp_quotient); end
    total++; if (bus.rsp_remainder !== 4'd1) begin bad++; $display("FAIL single_r got=%0d want=1", bus.rsp_remainder); end
    total++; if (bus.rsp_dbz !== 1'b0) begin bad++; $display("FAIL single_dbz got=%b want=0", bus.rsp_dbz); end
    tick();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL single_idle got busy=%b want=0", bus.busy); end
  endtask

  task automatic test_round_robin;
    int w;
    rst = 1'b1; tick(); rst = 1'b0;
    bus.req_dividend = {4'd9, 4'd15}; bus.req_divisor = {4'd3, 4'd2};
    bus.rsp_ready = 1'b1; bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL rr_first_grant got=%b want=01", bus.req_ready); end
    for (int n = 0; n < 6; n++) begin
      w = 0;
      while (!bus.rsp_valid && w < 20) begin tick(); w++; end
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL rr_valid op=%0d got=%b want=1", n, bus.rsp_valid); end
      total++; if (bus.rsp_id !== 1'(n % 2)) begin bad++; $display("FAIL rr_id op=%0d got=%0d want=%0d", n, bus.rsp_id, n % 2); end
      total++; if (bus.rsp_quotient !== ((n % 2) ? 4'd3 : 4'd7)) begin bad++; $display("FAIL rr_q op=%0d got=%0d want=%0d", n, bus.rsp_quotient, (n % 2) ? 3 : 7); end
      total++; if (bus.rsp_remainder !== ((n % 2) ? 4'd0 : 4'd1)) begin bad++; $display("FAIL rr_r op=%0d got=%0d want=%0d", n, bus.rsp_remainder, (n % 2) ? 0 : 1); end
      tick();
    end
    bus.req_valid = 2'b00;
    tick();
  endtask

  task automatic test_dbz;
    bus.req_dividend[7:4] = 4'd5; bus.req_divisor[7:4] = 4'd0;
    bus.rsp_ready = 1'b1; bus.req_valid = 2'b10;
    #1;
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL dbz_ready got=%b want=10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL dbz_valid got=%b want=1 at T+1", bus.rsp_valid); end
    total++; if (bus.rsp_id !== 1'b1) begin bad++; $display("FAIL dbz_id got=%0d want=1", bus.rsp_id); end
    total++; if (bus.rsp_quotient !== 4'hF) begin bad++; $display("FAIL dbz_q got=%h want=f", bus.rsp_quotient); end
    total++; if (bus.rsp_remainder !== 4'hF) begin bad++; $display("FAIL dbz_r got=%h want=f", bus.rsp_remainder); end
    total++; if (bus.rsp_dbz !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b want=1", bus.rsp_dbz); end
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL dbz_accept got=%b want=0", bus.rsp_valid); end
  endtask

  task automatic test_backpressure;
    int w;
    int leaks;
    bus.req_dividend = {4'd8, 4'd11}; bus.req_divisor = {4'd2, 4'd3};
    bus.rsp_ready = 1'b0; bus.req_valid = 2'b11;
    #1;
    total++; if (bus.req_ready !== 2'b01) begin bad++; $display("FAIL bp_grant got=%b want=01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b10;
    #1;
    w = 0; leaks = 0;
    while (!bus.rsp_valid && w < 20) begin
      if (bus.req_ready !== 2'b00) leaks++;
      tick(); w++;
    end
    total++; if (leaks !== 0) begin bad++; $display("FAIL bp_calc_ready got=%0d cycles with ready want=0", leaks); end
    for (int k = 0; k < 3; k++) begin
      total++; if (bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid k=%0d got=%b want=1", k, bus.rsp_valid); end
      total++; if (bus.rsp_quotient !== 4'd3) begin bad++; $display("FAIL bp_hold_q k=%0d got=%0d want=3", k, bus.rsp_quotient); end
      total++; if (bus.rsp_remainder !== 4'd2) begin bad++; $display("FAIL bp_hold_r k=%0d got=%0d want=2", k, bus.rsp_remainder); end
      total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_hold_ready k=%0d got=%b want=00", k, bus.req_ready); end
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    total++; if (bus.req_ready !== 2'b00) begin bad++; $display("FAIL bp_accept_ready got=%b want=00", bus.req_ready); end
    tick();
    total++; if (bus.req_ready !== 2'b10) begin bad++; $display("FAIL bp_next_grant got=%b want=10", bus.req_ready); end
    tick();
    bus.req_valid = 2'b00;
    w = 0;
    while (!bus.rsp_valid && w < 20) begin tick(); w++; end
    total++; if (bus.rsp_id !== 1'b1 || bus.rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_p1_id got=%0d valid=%b want=1 valid=1", bus.rsp_id, bus.rsp_valid); end
    total++; if (bus.rsp_quotient !== 4'd4) begin bad++; $display("FAIL bp_p1_q got=%0d want=4", bus.rsp_quotient); end
    total++; if (bus.rsp_remainder !== 4'd0) begin bad++; $display("FAIL bp_p1_r got=%0d want=0", bus.rsp_remainder); end
    tick();
  endtask

  task automatic test_rst_mid;
    int id, q, r, dz, seen;
    bus.req_dividend[3:0] = 4'd14; bus.req_divisor[3:0] = 4'd5;
    bus.rsp_ready = 1'b1; bus.req_valid = 2'b01;
    #1;
    tick();
    bus.req_valid = 2'b00;
    tick();
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rm_in_calc got busy=%b want=1", bus.busy); end
    rst = 1'b1;
    tick();
    total++; if (bus.rsp_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b want=0", bus.rsp_valid); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL rm_busy got=%b want=0", bus.busy); end
    total++; if (bus.rsp_quotient !== 4'h0) begin bad++; $display("FAIL rm_q got=%h want=0", bus.rsp_quotient); end
    total++; if (bus.rsp_remainder !== 4'h0) begin bad++; $display("FAIL rm_r got=%h want=0", bus.rsp_remainder); end
    total++; if (bus.rsp_id !== 1'b0 || bus.rsp_dbz !== 1'b0) begin bad++; $display("FAIL rm_id_dbz got id=%0d dbz=%b want 0 0", bus.rsp_id, bus.rsp_dbz); end
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (bus.rsp_valid) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rm_no_rsp got=%0d responses want=0", seen); end
    run_op(1, 7, 7, id, q, r, dz);
    total++; if (id !== 1) begin bad++; $display("FAIL rm_after_id got=%0d want=1", id); end
    total++; if (q !== 1 || r !== 0) begin bad++; $display("FAIL rm_after_qr got=%0d/%0d want=1/0", q, r); end
    total++; if (dz !== 0) begin bad++; $display("FAIL rm_after_dbz got=%0d want=0", dz); end
  endtask

  task automatic test_sweep;
    int id, q, r, dz, k;
    k = 0;
    for (int a = 0; a < 16; a++)
      for (int b = 1; b < 16; b++) begin
        run_op(k % 2, a, b, id, q, r, dz);
        total++; if (q !== a / b) begin bad++; $display("FAIL sweep_q %0d/%0d got=%0d want=%0d", a, b, q, a / b); end
        total++; if (r !== a % b) begin bad++; $display("FAIL sweep_r %0d%%%0d got=%0d want=%0d", a, b, r, a % b); end
        total++; if (id !== k % 2) begin bad++; $display("FAIL sweep_id %0d/%0d got=%0d want=%0d", a, b, id, k % 2); end
        k++;
      end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_dividend = '0;
    bus.req_divisor = '0;
    bus.rsp_ready = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_dbz();
    test_backpressure();
    test_rst_mid();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
